ioctl_sdram_loader: RTL and testbench

- Consumer end of the ioctl download stream; ex_hps_io is the producer and streams ROM words read from parallel flash.
- Accepts 16-bit ioctl words and forwards each one as a single write request to an sdram controller port, using a toggle req/ack handshake.
- Throttles the producer with ioctl_wait while a write is outstanding.
- Captures the ROM size at end of download and signals load completion to the Genesis core.

---
 rtl/ioctl_loader_pkg.sv | 19 +
 rtl/loader_ack_sync.sv | 31 +++
 rtl/ioctl_sdram_loader.sv | 173 +++++++++++++++++
 tb/tb_ioctl_sdram_loader.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ioctl_loader_pkg.sv
// rtl/ioctl_loader_pkg.sv - shared types, defaults and helpers for the ioctl sdram loader
package ioctl_loader_pkg;

  localparam int          DEF_AW        = 25;
  localparam int          DEF_DW        = 16;
  localparam logic [23:0] DEF_MAX_WORDS = 24'h400000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    PEND   = 2'd2,
    FINISH = 2'd3
  } loader_state_t;

  function automatic logic [15:0] byte_swap16(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/loader_ack_sync.sv
// rtl/loader_ack_sync.sv - two-flop synchronizer for signals crossing in from another clock domain
module loader_ack_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ioctl_sdram_loader.sv
// rtl/ioctl_sdram_loader.sv - ioctl download consumer forwarding each word as one sdram write request
module ioctl_sdram_loader
  import ioctl_loader_pkg::*;
#(
  parameter int            AW        = DEF_AW,
  parameter int            DW        = DEF_DW,
  parameter logic [7:0]    INDEX     = 8'h00,
  parameter bit            SWAP      = 1'b1,
  parameter logic [AW-2:0] MAX_WORDS = (AW-1)'(DEF_MAX_WORDS)
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [DW-1:0] ioctl_dout,
  output logic          ioctl_wait,
  output logic [AW-2:0] sdr_addr,
  output logic [DW-1:0] sdr_din,
  output logic          sdr_req,
  input  logic          sdr_ack,
  output logic [AW-1:0] rom_sz,
  output logic          rom_sz_valid,
  output logic          load_busy,
  output logic          load_done,
  output logic          overflow,
  output logic          proto_err
);

  loader_state_t state_q, state_d;
  logic          req_q, req_d;
  logic [AW-2:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          wait_q, wait_d;
  logic [AW-1:0] rom_sz_q, rom_sz_d;
  logic          rom_sz_valid_q, rom_sz_valid_d;
  logic          done_q, done_d;
  logic          overflow_q, overflow_d;
  logic          proto_err_q, proto_err_d;
  logic          dl_q, dl_d;

  logic          ack_s;
  logic          pending;
  logic          dl_rise;
  logic          dl_fall;
  logic [AW-2:0] word_addr;
  logic [DW-1:0] wr_data;

  loader_ack_sync #(.W(1)) u_ack_sync (
    .clk (clk_sys),
    .rst (reset),
    .d   (sdr_ack),
    .q   (ack_s)
  );

  always_comb begin
    pending   = (req_q != ack_s);
    dl_rise   = ioctl_download & ~dl_q;
    dl_fall   = ~ioctl_download & dl_q;
    word_addr = ioctl_addr[AW-1:1];
    wr_data   = SWAP ? DW'(byte_swap16(16'(ioctl_dout))) : ioctl_dout;
  end

  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    addr_d         = addr_q;
    din_d          = din_q;
    wait_d         = wait_q;
    rom_sz_d       = rom_sz_q;
    rom_sz_valid_d = rom_sz_valid_q;
    done_d         = 1'b0;
    overflow_d     = overflow_q;
    proto_err_d    = proto_err_q;
    dl_d           = ioctl_download;

    case (state_q)
      IDLE: begin
        // Absorb any ack toggle left over from a write that straddled reset.
        if (pending) req_d = ack_s;
        if (dl_rise && ioctl_index == INDEX) begin
          state_d        = ARMED;
          rom_sz_valid_d = 1'b0;
          overflow_d     = 1'b0;
          proto_err_d    = 1'b0;
        end
      end

      ARMED: begin
        if (ioctl_wr) begin
          if (word_addr < MAX_WORDS) begin
            addr_d  = word_addr;
            din_d   = wr_data;
            req_d   = ~req_q;
            wait_d  = 1'b1;
            state_d = PEND;
          end else begin
            overflow_d = 1'b1;
          end
        end
        // A same-cycle write is already issued above; FINISH waits for its ack.
        if (dl_fall) begin
          rom_sz_d = ioctl_addr;
          state_d  = FINISH;
        end
      end

      PEND: begin
        if (ioctl_wr) proto_err_d = 1'b1;
        if (!pending) begin
          wait_d  = 1'b0;
          state_d = ARMED;
        end
        if (dl_fall) begin
          rom_sz_d = ioctl_addr;
          state_d  = FINISH;
        end
      end

      FINISH: begin
        if (!pending) begin
          wait_d         = 1'b0;
          rom_sz_valid_d = 1'b1;
          done_d         = 1'b1;
          state_d        = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      req_q          <= 1'b0;
      addr_q         <= '0;
      din_q          <= '0;
      wait_q         <= 1'b0;
      rom_sz_q       <= '0;
      rom_sz_valid_q <= 1'b0;
      done_q         <= 1'b0;
      overflow_q     <= 1'b0;
      proto_err_q    <= 1'b0;
      dl_q           <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      addr_q         <= addr_d;
      din_q          <= din_d;
      wait_q         <= wait_d;
      rom_sz_q       <= rom_sz_d;
      rom_sz_valid_q <= rom_sz_valid_d;
      done_q         <= done_d;
      overflow_q     <= overflow_d;
      proto_err_q    <= proto_err_d;
      dl_q           <= dl_d;
    end
  end

  assign ioctl_wait   = wait_q;
  assign sdr_addr     = addr_q;
  assign sdr_din      = din_q;
  assign sdr_req      = req_q;
  assign rom_sz       = rom_sz_q;
  assign rom_sz_valid = rom_sz_valid_q;
  assign load_busy    = (state_q != IDLE);
  assign load_done    = done_q;
  assign overflow     = overflow_q;
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// tb/tb_ioctl_sdram_loader.sv - scoreboard bench for ioctl_sdram_loader
module tb_ioctl_sdram_loader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [15:0] ioctl_dout = '0;
  logic        sdr_ack = 1'b0;

  logic        ioctl_wait;
  logic [23:0] sdr_addr;
  logic [15:0] sdr_din;
  logic        sdr_req;
  logic [24:0] rom_sz;
  logic        rom_sz_valid;
  logic        load_busy;
  logic        load_done;
  logic        overflow;
  logic        proto_err;

  int          total = 0;
  int          bad = 0;
  int          req_toggles = 0;
  logic [39:0] exp_q[$];
  logic        req_prev = 1'b0;

  always #5 clk_sys = ~clk_sys;

  ioctl_sdram_loader dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .sdr_addr       (sdr_addr),
    .sdr_din        (sdr_din),
    .sdr_req        (sdr_req),
    .sdr_ack        (sdr_ack),
    .rom_sz         (rom_sz),
    .rom_sz_valid   (rom_sz_valid),
    .load_busy      (load_busy),
    .load_done      (load_done),
    .overflow       (overflow),
    .proto_err      (proto_err)
  );

  // Every sdr_req toggle is one sdram write; pop and compare against the expected write.
  always @(negedge clk_sys) begin : monitor
    logic [39:0] e;
    if (reset) begin
      req_prev = sdr_req;
    end else if (sdr_req !== req_prev) begin
      req_prev = sdr_req;
      req_toggles++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sdr_req_unexpected got addr=%h din=%h exp none", sdr_addr, sdr_din);
      end else begin
        e = exp_q.pop_front();
        if ({sdr_addr, sdr_din} !== e) begin
          bad++;
          $display("FAIL sdr_write got addr=%h din=%h exp addr=%h din=%h", sdr_addr, sdr_din, e[39:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic put_word(input logic [24:0] a, input logic [15:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic expect_req(input logic [24:0] a, input logic [15:0] d);
    exp_q.push_back({a[24:1], d[7:0], d[15:8]});
  endtask

  task automatic wait_release(input int budget, output int cycles);
    cycles = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_sys);
      if (ioctl_wait === 1'b0) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge clk_sys);
      if (load_done === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset;
    tick(2);
    @(negedge clk_sys);
    total++; if (ioctl_wait !== 1'b0)   begin bad++; $display("FAIL reset_wait got=%b exp=0", ioctl_wait); end
    total++; if (sdr_req !== 1'b0)      begin bad++; $display("FAIL reset_req got=%b exp=0", sdr_req); end
    total++; if (sdr_addr !== 24'h0)    begin bad++; $display("FAIL reset_addr got=%h exp=0", sdr_addr); end
    total++; if (sdr_din !== 16'h0)     begin bad++; $display("FAIL reset_din got=%h exp=0", sdr_din); end
    total++; if (rom_sz !== 25'h0)      begin bad++; $display("FAIL reset_rom_sz got=%h exp=0", rom_sz); end
    total++; if ({rom_sz_valid, load_busy, load_done, overflow, proto_err} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=00000", {rom_sz_valid, load_busy, load_done, overflow, proto_err});
    end
    tick();
    reset = 1'b0;
    tick(3);
  endtask

  task automatic test_single_word;
    int p;
    tick(4);
    start_dl(8'h00);
    expect_req(25'h000002, 16'h1234);
    put_word(25'h000002, 16'h1234);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      total++; if (ioctl_wait !== 1'b1) begin bad++; $display("FAIL single_wait_before_ack got=%b exp=1", ioctl_wait); end
    end
    total++; if (sdr_addr !== 24'h000001 || sdr_din !== 16'h3412) begin
      bad++; $display("FAIL single_data got addr=%h din=%h exp addr=000001 din=3412", sdr_addr, sdr_din);
    end
    @(posedge clk_sys); #1;
    sdr_ack = ~sdr_ack;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      total++; if (ioctl_wait !== 1'b1) begin bad++; $display("FAIL single_wait_after_ack got=%b exp=1 cyc=%0d", ioctl_wait, i); end
    end
    @(negedge clk_sys);
    total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL single_wait_release got=%b exp=0", ioctl_wait); end
    tick();
    ioctl_addr = 25'h000004;
    ioctl_download = 1'b0;
    count_done(6, p);
    total++; if (p != 1) begin bad++; $display("FAIL single_done_pulses got=%0d exp=1", p); end
    total++; if (rom_sz !== 25'h4 || rom_sz_valid !== 1'b1 || load_busy !== 1'b0) begin
      bad++; $display("FAIL single_rom_sz got sz=%h v=%b busy=%b exp sz=4 v=1 busy=0", rom_sz, rom_sz_valid, load_busy);
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL single_missing_req got=%0d exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_stream;
    int p, cyc, t0;
    logic [15:0] d;
    tick(4);
    t0 = req_toggles;
    start_dl(8'h00);
    for (int i = 0; i < 512; i++) begin
      d = 16'($urandom);
      expect_req(25'(2 * i), d);
      put_word(25'(2 * i), d);
      tick(int'($urandom_range(0, 3)));
      sdr_ack = ~sdr_ack;
      wait_release(8, cyc);
      total++;
      if (cyc != 3) begin
        bad++; $display("FAIL stream_wait_release got=%0d exp=3 word=%0d", cyc, i);
        if (cyc < 0) break;
      end
      tick();
    end
    ioctl_addr = 25'h000400;
    ioctl_download = 1'b0;
    count_done(6, p);
    total++; if (p != 1) begin bad++; $display("FAIL stream_done_pulses got=%0d exp=1", p); end
    total++; if (req_toggles - t0 != 512) begin bad++; $display("FAIL stream_req_count got=%0d exp=512", req_toggles - t0); end
    total++; if (rom_sz !== 25'h400 || rom_sz_valid !== 1'b1) begin
      bad++; $display("FAIL stream_rom_sz got sz=%h v=%b exp sz=400 v=1", rom_sz, rom_sz_valid);
    end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL stream_proto_err got=%b exp=0", proto_err); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stream_missing_req got=%0d exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_index_filter;
    int p, t0;
    tick(4);
    t0 = req_toggles;
    start_dl(8'h01);
    for (int i = 0; i < 4; i++) begin
      put_word(25'(2 * i), 16'(16'hA5A0 + i));
      @(negedge clk_sys);
      total++; if (ioctl_wait !== 1'b0 || load_busy !== 1'b0) begin
        bad++; $display("FAIL filter_idle got wait=%b busy=%b exp wait=0 busy=0", ioctl_wait, load_busy);
      end
      tick();
    end
    ioctl_download = 1'b0;
    count_done(6, p);
    total++; if (p != 0) begin bad++; $display("FAIL filter_done got=%0d exp=0", p); end
    total++; if (req_toggles != t0) begin bad++; $display("FAIL filter_req got=%0d exp=%0d", req_toggles, t0); end
  endtask

  task automatic test_overflow;
    int p, cyc, t0;
    tick(4);
    start_dl(8'h00);
    @(negedge clk_sys);
    total++; if (rom_sz_valid !== 1'b0 || load_busy !== 1'b1) begin
      bad++; $display("FAIL ovf_arm got v=%b busy=%b exp v=0 busy=1", rom_sz_valid, load_busy);
    end
    tick();
    t0 = req_toggles;
    put_word(25'h800000, 16'hDEAD);
    @(negedge clk_sys);
    total++; if (overflow !== 1'b1 || ioctl_wait !== 1'b0 || req_toggles != t0) begin
      bad++; $display("FAIL ovf_reject got ovf=%b wait=%b reqs=%0d exp ovf=1 wait=0 reqs=%0d", overflow, ioctl_wait, req_toggles, t0);
    end
    tick();
    expect_req(25'h7FFFFE, 16'hBEEF);
    put_word(25'h7FFFFE, 16'hBEEF);
    sdr_ack = ~sdr_ack;
    wait_release(8, cyc);
    total++; if (cyc != 3) begin bad++; $display("FAIL ovf_last_word_release got=%0d exp=3", cyc); end
    tick();
    ioctl_addr = 25'h800000;
    ioctl_download = 1'b0;
    count_done(6, p);
    total++; if (p != 1 || overflow !== 1'b1 || rom_sz !== 25'h800000) begin
      bad++; $display("FAIL ovf_finish got done=%0d ovf=%b sz=%h exp done=1 ovf=1 sz=800000", p, overflow, rom_sz);
    end
    tick(4);
    start_dl(8'h00);
    @(negedge clk_sys);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    tick();
    ioctl_download = 1'b0;
    count_done(6, p);
    total++; if (p != 1) begin bad++; $display("FAIL ovf_empty_done got=%0d exp=1", p); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL ovf_missing_req got=%0d exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_proto_late_ack;
    int p;
    tick(4);
    start_dl(8'h00);
    expect_req(25'h000010, 16'h1180);
    put_word(25'h000010, 16'h1180);
    put_word(25'h000012, 16'h2233);
    @(negedge clk_sys);
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_flag got=%b exp=1", proto_err); end
    total++; if (sdr_addr !== 24'h000008 || sdr_din !== 16'h8011) begin
      bad++; $display("FAIL proto_drop got addr=%h din=%h exp addr=000008 din=8011", sdr_addr, sdr_din);
    end
    tick();
    ioctl_addr = 25'h000014;
    ioctl_download = 1'b0;
    count_done(6, p);
    total++; if (p != 0 || load_busy !== 1'b1 || ioctl_wait !== 1'b1) begin
      bad++; $display("FAIL late_ack_hold got done=%0d busy=%b wait=%b exp done=0 busy=1 wait=1", p, load_busy, ioctl_wait);
    end
    tick();
    sdr_ack = ~sdr_ack;
    count_done(6, p);
    total++; if (p != 1) begin bad++; $display("FAIL late_ack_done got=%0d exp=1", p); end
    total++; if (rom_sz !== 25'h14 || rom_sz_valid !== 1'b1 || ioctl_wait !== 1'b0 || proto_err !== 1'b1) begin
      bad++; $display("FAIL late_ack_end got sz=%h v=%b wait=%b perr=%b exp sz=14 v=1 wait=0 perr=1", rom_sz, rom_sz_valid, ioctl_wait, proto_err);
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL proto_missing_req got=%0d exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    int p;
    tick(4);
    start_dl(8'h00);
    expect_req(25'h000020, 16'h5566);
    ioctl_addr = 25'h000020;
    ioctl_dout = 16'h5566;
    ioctl_wr = 1'b1;
    ioctl_download = 1'b0;
    tick();
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    total++; if (ioctl_wait !== 1'b1 || load_busy !== 1'b1 || proto_err !== 1'b0) begin
      bad++; $display("FAIL wr_fall_pending got wait=%b busy=%b perr=%b exp wait=1 busy=1 perr=0", ioctl_wait, load_busy, proto_err);
    end
    tick();
    sdr_ack = ~sdr_ack;
    count_done(6, p);
    total++; if (p != 1 || rom_sz !== 25'h20) begin
      bad++; $display("FAIL wr_fall_done got done=%0d sz=%h exp done=1 sz=20", p, rom_sz);
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL wr_fall_missing_req got=%0d exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_pend;
    int p, cyc;
    tick(4);
    start_dl(8'h00);
    expect_req(25'h000030, 16'h7788);
    put_word(25'h000030, 16'h7788);
    @(negedge clk_sys);
    tick();
    sdr_ack = ~sdr_ack;
    reset = 1'b1;
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    total++; if (ioctl_wait !== 1'b0 || sdr_req !== 1'b0 || load_busy !== 1'b0 || rom_sz_valid !== 1'b0) begin
      bad++; $display("FAIL mid_reset got wait=%b req=%b busy=%b v=%b exp all 0", ioctl_wait, sdr_req, load_busy, rom_sz_valid);
    end
    if (sdr_ack === 1'b1) exp_q.push_back(40'h0);
    tick();
    reset = 1'b0;
    tick(5);
    @(negedge clk_sys);
    total++; if (sdr_req !== sdr_ack || ioctl_wait !== 1'b0) begin
      bad++; $display("FAIL resync got req=%b wait=%b exp req=%b wait=0", sdr_req, ioctl_wait, sdr_ack);
    end
    tick();
    start_dl(8'h00);
    expect_req(25'h000032, 16'h99AA);
    put_word(25'h000032, 16'h99AA);
    sdr_ack = ~sdr_ack;
    wait_release(8, cyc);
    total++; if (cyc != 3) begin bad++; $display("FAIL post_reset_release got=%0d exp=3", cyc); end
    tick();
    ioctl_addr = 25'h000034;
    ioctl_download = 1'b0;
    count_done(6, p);
    total++; if (p != 1 || rom_sz !== 25'h34) begin
      bad++; $display("FAIL post_reset_done got done=%0d sz=%h exp done=1 sz=34", p, rom_sz);
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL post_reset_missing_req got=%0d exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_stream();
    test_index_filter();
    test_overflow();
    test_proto_late_ack();
    test_back_to_back();
    test_reset_mid_pend();
    tick(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
